// File: rtl/pcie_perst_sequencer_if.sv
// PCIe PERST# sequencer signal bundle (board/SW side <-> sequencer).
// master: drives pwr_good_i, sw_reset_req_i, link_up_i; slave: the sequencer.
interface pcie_perst_sequencer_if;
    logic       pwr_good_i;
    logic       sw_reset_req_i;
    logic       link_up_i;
    logic       refclk_en_o;
    logic       perst_n_o;
    logic       link_ok_o;
    logic       timeout_o;
    logic [2:0] state_o;
    logic [1:0] retry_cnt_o;

    modport master (
        output pwr_good_i, sw_reset_req_i, link_up_i,
        input  refclk_en_o, perst_n_o, link_ok_o,
        input  timeout_o, state_o, retry_cnt_o
    );

    modport slave (
        input  pwr_good_i, sw_reset_req_i, link_up_i,
        output refclk_en_o, perst_n_o, link_ok_o,
        output timeout_o, state_o, retry_cnt_o
    );
endinterface

// File: rtl/pcie_perst_sequencer.sv
// Root-side PCIe fundamental-reset sequencer: power-good -> refclk -> PERST#.
// Ports: clk, rst_n (async low), bus (slave modport: pwr_good_i,
// sw_reset_req_i, link_up_i in; refclk_en_o, perst_n_o, link_ok_o,
// timeout_o, state_o[2:0], retry_cnt_o[1:0] out).
// Option: PCIE_PERST_RETRY_EN enables automatic re-assert on link timeout.
module pcie_perst_sequencer #(
    parameter int PWR_STABLE_CYCLES     = 1000,
    parameter int REFCLK_STABLE_CYCLES  = 100,
    parameter int MIN_ASSERT_CYCLES     = 100,
    parameter int LINKUP_TIMEOUT_CYCLES = 10000,
    parameter int MAX_RETRIES           = 3
) (
    input logic                   clk,
    input logic                   rst_n,
    pcie_perst_sequencer_if.slave bus
);

`ifdef PCIE_PERST_RETRY_EN
    localparam bit RETRY_EN = 1'b1;
`else
    localparam bit RETRY_EN = 1'b0;
`endif

    localparam int MAX_A = (PWR_STABLE_CYCLES > REFCLK_STABLE_CYCLES) ?
                           PWR_STABLE_CYCLES : REFCLK_STABLE_CYCLES;
    localparam int MAX_B = (MIN_ASSERT_CYCLES > LINKUP_TIMEOUT_CYCLES) ?
                           MIN_ASSERT_CYCLES : LINKUP_TIMEOUT_CYCLES;
    localparam int MAX_P = (MAX_A > MAX_B) ? MAX_A : MAX_B;
    localparam int CW    = $clog2(MAX_P + 1);

    // Terminal counts: the counter starts at 0 on state entry, so the
    // last cycle of an N-cycle residency sees N-1.
    localparam logic [CW-1:0] PWR_TC = CW'(PWR_STABLE_CYCLES - 1);
    localparam logic [CW-1:0] CLK_TC = CW'(REFCLK_STABLE_CYCLES - 1);
    localparam logic [CW-1:0] AST_TC = CW'(MIN_ASSERT_CYCLES - 1);
    localparam logic [CW-1:0] LNK_TC = CW'(LINKUP_TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        S_OFF       = 3'd0,
        S_PWR_WAIT  = 3'd1,
        S_CLK_WAIT  = 3'd2,
        S_LINK_WAIT = 3'd3,
        S_UP        = 3'd4,
        S_ASSERT    = 3'd5,
        S_FAIL      = 3'd6
    } state_e;

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          timeout_q, timeout_d;
    logic [1:0]    retry_q, retry_d;
    logic          refclk_q, perst_q, link_ok_q;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        timeout_d = timeout_q;
        retry_d   = retry_q;
        if (state_q != S_OFF && !bus.pwr_good_i) begin
            state_d = S_OFF;
        end else if (bus.sw_reset_req_i &&
                     state_q != S_OFF && state_q != S_PWR_WAIT) begin
            // Also restarts the count when already in ASSERT.
            state_d   = S_ASSERT;
            cnt_d     = '0;
            timeout_d = 1'b0;
            retry_d   = '0;
        end else begin
            unique case (state_q)
                S_OFF: begin
                    if (bus.pwr_good_i) state_d = S_PWR_WAIT;
                end
                S_PWR_WAIT: begin
                    if (cnt_q == PWR_TC) state_d = S_CLK_WAIT;
                    else cnt_d = cnt_q + CW'(1);
                end
                S_CLK_WAIT: begin
                    if (cnt_q == CLK_TC) state_d = S_LINK_WAIT;
                    else cnt_d = cnt_q + CW'(1);
                end
                S_LINK_WAIT: begin
                    if (bus.link_up_i) begin
                        state_d = S_UP;
                    end else if (cnt_q == LNK_TC) begin
                        timeout_d = 1'b1;
                        if (RETRY_EN && int'(retry_q) < MAX_RETRIES) begin
                            state_d = S_ASSERT;
                            if (retry_q != 2'd3) retry_d = retry_q + 2'd1;
                        end else begin
                            state_d = S_FAIL;
                        end
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
                S_UP: begin
                    if (!bus.link_up_i) state_d = S_LINK_WAIT;
                end
                S_ASSERT: begin
                    if (cnt_q == AST_TC) state_d = S_CLK_WAIT;
                    else cnt_d = cnt_q + CW'(1);
                end
                S_FAIL: begin
                    state_d = S_FAIL;
                end
                default: begin
                    state_d = S_OFF;
                end
            endcase
        end
        if (state_d != state_q) cnt_d = '0;
        if (state_d == S_OFF) begin
            timeout_d = 1'b0;
            retry_d   = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_OFF;
            cnt_q     <= '0;
            timeout_q <= 1'b0;
            retry_q   <= '0;
            refclk_q  <= 1'b0;
            perst_q   <= 1'b0;
            link_ok_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            timeout_q <= timeout_d;
            retry_q   <= retry_d;
            refclk_q  <= (state_q == S_CLK_WAIT) || (state_q == S_LINK_WAIT) ||
                         (state_q == S_UP) || (state_q == S_ASSERT) ||
                         (state_q == S_FAIL);
            perst_q   <= (state_q == S_LINK_WAIT) || (state_q == S_UP);
            link_ok_q <= (state_q == S_UP);
        end
    end

    assign bus.state_o     = state_q;
    assign bus.refclk_en_o = refclk_q;
    assign bus.perst_n_o   = perst_q;
    assign bus.link_ok_o   = link_ok_q;
    assign bus.timeout_o   = timeout_q;
    assign bus.retry_cnt_o = retry_q;

endmodule

// File: tb/tb_pcie_perst_sequencer.sv
// Bench for pcie_perst_sequencer: power-up table, SW reset, glitch,
// link timeout (retry or not), simultaneous requests, async reset.
module tb_pcie_perst_sequencer;
    localparam int PWR  = 10;
    localparam int REF  = 5;
    localparam int ASR  = 4;
    localparam int TO   = 20;
    localparam int MAXR = 2;

`ifdef PCIE_PERST_RETRY_EN
    localparam int EXP_ASSERTS = 2;
    localparam int EXP_RETRY   = 2;
    localparam int EXP_LAT     = 3 * TO + 2 * (ASR + REF);
`else
    localparam int EXP_ASSERTS = 0;
    localparam int EXP_RETRY   = 0;
    localparam int EXP_LAT     = TO;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    pcie_perst_sequencer_if bus ();

    pcie_perst_sequencer #(
        .PWR_STABLE_CYCLES    (PWR),
        .REFCLK_STABLE_CYCLES (REF),
        .MIN_ASSERT_CYCLES    (ASR),
        .LINKUP_TIMEOUT_CYCLES(TO),
        .MAX_RETRIES          (MAXR)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    int total = 0;
    int bad   = 0;

    typedef struct {
        int         cyc;
        logic       refclk;
        logic       perst;
        logic       lok;
        logic [2:0] st;
    } vec_t;

    vec_t pv[10];

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic int st;
        return int'(bus.state_o);
    endfunction

    // Entered between edges with pwr_good low; next edge is cycle 0.
    task automatic powerup(input string tag);
        tick;
        for (int c = 0; c <= 33; c++) begin
            foreach (pv[k]) begin
                if (pv[k].cyc == c) begin
                    chk($sformatf("%s c%0d state", tag, c), st(), int'(pv[k].st));
                    chk($sformatf("%s c%0d refclk", tag, c),
                        int'(bus.refclk_en_o), int'(pv[k].refclk));
                    chk($sformatf("%s c%0d perst", tag, c),
                        int'(bus.perst_n_o), int'(pv[k].perst));
                    chk($sformatf("%s c%0d link_ok", tag, c),
                        int'(bus.link_ok_o), int'(pv[k].lok));
                end
            end
            bus.pwr_good_i = 1'b1;
            bus.link_up_i  = (c >= 30);
            tick;
        end
    endtask

    initial begin
        int n_assert, n_plow, n_rlow, hi, first_clk;
        int lw_start, fail_at, asserts, prev, found;

        pv[0] = '{0,  1'b0, 1'b0, 1'b0, 3'd0};
        pv[1] = '{1,  1'b0, 1'b0, 1'b0, 3'd1};
        pv[2] = '{10, 1'b0, 1'b0, 1'b0, 3'd1};
        pv[3] = '{11, 1'b0, 1'b0, 1'b0, 3'd2};
        pv[4] = '{12, 1'b1, 1'b0, 1'b0, 3'd2};
        pv[5] = '{16, 1'b1, 1'b0, 1'b0, 3'd3};
        pv[6] = '{17, 1'b1, 1'b1, 1'b0, 3'd3};
        pv[7] = '{30, 1'b1, 1'b1, 1'b0, 3'd3};
        pv[8] = '{31, 1'b1, 1'b1, 1'b0, 3'd4};
        pv[9] = '{32, 1'b1, 1'b1, 1'b1, 3'd4};

        bus.pwr_good_i     = 1'b0;
        bus.sw_reset_req_i = 1'b0;
        bus.link_up_i      = 1'b0;

        #3;
        chk("rst state", st(), 0);
        chk("rst refclk", int'(bus.refclk_en_o), 0);
        chk("rst perst", int'(bus.perst_n_o), 0);
        chk("rst link_ok", int'(bus.link_ok_o), 0);
        chk("rst timeout", int'(bus.timeout_o), 0);
        chk("rst retry", int'(bus.retry_cnt_o), 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Power-up from cycle 0; ends in UP at cycle 34.
        powerup("t1");

        // SW reset in UP.
        bus.sw_reset_req_i = 1'b1;
        tick;
        bus.sw_reset_req_i = 1'b0;
        n_assert = 0; n_plow = 0; n_rlow = 0;
        for (int i = 0; i < 12; i++) begin
            if (st() == 5) n_assert++;
            if (!bus.perst_n_o) n_plow++;
            if (!bus.refclk_en_o) n_rlow++;
            tick;
        end
        chk("t3 assert cycles", n_assert, ASR);
        chk("t3 perst low cycles", n_plow, ASR + REF);
        chk("t3 refclk low cycles", n_rlow, 0);
        chk("t3 end state", st(), 4);
        chk("t3 end perst", int'(bus.perst_n_o), 1);
        chk("t3 end link_ok", int'(bus.link_ok_o), 1);

        // Power loss and SW reset together in UP.
        bus.pwr_good_i     = 1'b0;
        bus.sw_reset_req_i = 1'b1;
        tick;
        bus.sw_reset_req_i = 1'b0;
        bus.link_up_i      = 1'b0;
        chk("t5 state", st(), 0);
        tick;
        chk("t5 refclk", int'(bus.refclk_en_o), 0);
        chk("t5 perst", int'(bus.perst_n_o), 0);
        chk("t5 link_ok", int'(bus.link_ok_o), 0);
        chk("t5 state hold", st(), 0);

        // One-cycle power glitch during PWR_WAIT.
        bus.pwr_good_i = 1'b1;
        tick;
        chk("t2 pwr_wait", st(), 1);
        repeat (4) tick;
        bus.pwr_good_i = 1'b0;
        tick;
        chk("t2 glitch off", st(), 0);
        chk("t2 glitch refclk", int'(bus.refclk_en_o), 0);
        bus.pwr_good_i = 1'b1;
        hi = 0;
        first_clk = -1;
        for (int i = 0; i < 11; i++) begin
            tick;
            if (bus.refclk_en_o) hi++;
            if (st() == 2 && first_clk < 0) first_clk = i;
        end
        chk("t2 clk_wait index", first_clk, PWR);
        chk("t2 refclk early", hi, 0);
        tick;
        chk("t2 refclk on", int'(bus.refclk_en_o), 1);

        // No link: timeout path.
        lw_start = -1; fail_at = -1; asserts = 0; prev = st();
        for (int i = 0; i < 200 && fail_at < 0; i++) begin
            tick;
            if (st() == 3 && lw_start < 0) lw_start = i;
            if (st() == 5 && prev != 5) asserts++;
            if (st() == 6) fail_at = i;
            prev = st();
        end
        chk("t4 reached fail", int'(fail_at >= 0), 1);
        chk("t4 fail latency", fail_at - lw_start, EXP_LAT);
        chk("t4 asserts", asserts, EXP_ASSERTS);
        chk("t4 timeout", int'(bus.timeout_o), 1);
        tick;
        chk("t4 state", st(), 6);
        chk("t4 perst", int'(bus.perst_n_o), 0);
        chk("t4 refclk", int'(bus.refclk_en_o), 1);
        chk("t4 retry", int'(bus.retry_cnt_o), EXP_RETRY);

        // SW reset out of FAIL clears sticky flags.
        bus.sw_reset_req_i = 1'b1;
        tick;
        bus.sw_reset_req_i = 1'b0;
        chk("fail sw state", st(), 5);
        chk("fail sw timeout", int'(bus.timeout_o), 0);
        chk("fail sw retry", int'(bus.retry_cnt_o), 0);

        // Async reset mid-LINK_WAIT, then replay power-up.
        found = 0;
        for (int i = 0; i < 50 && found == 0; i++) begin
            tick;
            if (st() == 3) found = 1;
        end
        chk("t6 reached link_wait", found, 1);
        repeat (3) tick;
        chk("t6 pre perst", int'(bus.perst_n_o), 1);
        #3;
        rst_n = 1'b0;
        #1;
        chk("t6 async state", st(), 0);
        chk("t6 async refclk", int'(bus.refclk_en_o), 0);
        chk("t6 async perst", int'(bus.perst_n_o), 0);
        chk("t6 async link_ok", int'(bus.link_ok_o), 0);
        chk("t6 async timeout", int'(bus.timeout_o), 0);
        bus.pwr_good_i = 1'b0;
        #2;
        rst_n = 1'b1;
        powerup("t6");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
